// File: rtl/serial_byte_deframer.sv
// Serial-line receiver: start detect, 8 data bits LSB-first, optional parity, stop check, 1-byte buffer.
// Optional parity bit enabled by defining PARITY_EN.
module serial_byte_deframer #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  localparam logic [7:0] HALF = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d;
  logic       overrun_q, overrun_d;
  logic       sample;
  logic       par_bad;
  logic       commit;

  assign sample = (cnt_q == LAST);

`ifdef PARITY_EN
  assign par_bad = par_q != (^shift_q ^ PARITY_ODD);
`else
  // Parity option compiled out; keep the parameter referenced.
  logic unused_parity;
  assign unused_parity = PARITY_ODD ^ par_q;
  assign par_bad       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    commit       = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ser_in) begin
          bit_d = 3'd0;
          // With one clock per bit the start bit is confirmed on the detection cycle.
          if (HALF == 8'd0) begin
            state_d = DATA;
            cnt_d   = 8'd0;
          end else begin
            state_d = START;
            cnt_d   = 8'd1;
          end
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = 8'd0;
          state_d = ser_in ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d   = 8'd0;
          shift_d = {ser_in, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PARITY: begin
        if (sample) begin
          cnt_d   = 8'd0;
          par_d   = ser_in;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (sample) begin
          cnt_d        = 8'd0;
          parity_err_d = par_bad;
          if (ser_in) begin
            state_d = IDLE;
            commit  = !par_bad;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_HIGH: if (ser_in) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // A simultaneous drain frees the buffer, so only a stalled full buffer overruns.
    if (commit) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_data_d  = shift_q;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      out_data_q   <= 8'd0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
